rat_md_sched: RTL
=================

Name: rat_md_sched

Overview:
- Two-requester scheduler that shares one rational mul_div unit (the module computing (l_num/l_den) × or ÷ (r_num/r_den)).
- Arbitrates round-robin between requesters with valid/ready handshakes.
- Drives the unit's operands and mode, waits a fixed latency, then captures the result.
- Returns the result on one response channel tagged with the requester id; zero result denominators are flagged as errors.

Parameters:
- WIDTH, 32, width of each numerator/denominator, matching mul_div WIDTH.
- LATENCY, 2, clock cycles from operands driven to s_num/s_den valid; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  scheduler accepts requester 0 this cycle.
- req0_div  in  1  1 = divide, 0 = multiply.
- req0_ops  in  4*WIDTH  {l_num, l_den, r_num, r_den}, l_num in MSBs.
- req1_valid, req1_ready, req1_div, req1_ops  same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the response.
- rsp_num  out  WIDTH  result numerator.
- rsp_den  out  WIDTH  result denominator.
- rsp_err  out  1  rsp_den == 0.
- busy  out  1  state != IDLE.
- md_enable_div  out  1  to mul_div enable_div.
- md_l_num, md_l_den, md_r_num, md_r_den  out  WIDTH each  to mul_div operands.
- md_s_num, md_s_den  in  WIDTH each  from mul_div.

Behaviour:
- Reset (rst low, asynchronous) forces the following, and holds it while rst is low:
  - state = IDLE; wait counter = 0; last_grant = 1, so requester 0 has first priority.
  - All outputs 0: rsp_*, md_*, busy, reqN_ready.
- FSM states: IDLE, WAIT, RESP.
- IDLE, grant selection:
  - Only one valid → grant it.
  - Both valid → grant !last_grant.
  - reqN_ready is combinational: high only in IDLE and only for the granted requester; never both high together.
- IDLE, acceptance at edge T (valid & ready):
  - Latch the granted ops and div into the md_* registers.
  - Record the id; last_grant = id; counter = 0; go to WAIT.
  - No valid → stay IDLE; md_* keep their last values.
- WAIT:
  - Counter increments each cycle; md_* held constant.
  - When counter == LATENCY-1, at that edge: capture md_s_num → rsp_num, md_s_den → rsp_den, rsp_err = (md_s_den == 0), rsp_id = recorded id; set rsp_valid; go to RESP.
- Timing:
  - rsp_valid is first high in cycle T+LATENCY+1.
  - Accept-to-response latency is LATENCY+1 cycles.
- RESP:
  - rsp_* held stable while rsp_valid & !rsp_ready.
  - On the rsp_ready edge: clear rsp_valid, go to IDLE.
  - Earliest next acceptance is the cycle after the handshake; peak throughput is one op per LATENCY+2 cycles.
- No request is accepted while busy; requester valids may stay asserted and wait.
- Arithmetic is performed by mul_div (products truncated to WIDTH). The scheduler does no arithmetic except the zero compare.
  - Divide by r_num = 0 therefore yields den 0 and sets err.
  - l_den = 0 or r_den = 0 on a multiply also sets err.
- A requester deasserting valid while not granted is legal. Ops/div must stay stable only in the accept cycle.
- Reset mid-WAIT or mid-RESP:
  - The in-flight op is discarded; no response is emitted after release.
  - Priority returns to requester 0.
- Back-to-back with both valid continuously: grants alternate 0,1,0,1.

Test Plan:
- Mul, single requester: req0 ops (3,4,5,7), div=0 → accept in one cycle, rsp_valid exactly 3 cycles later, rsp 15/28, id 0, err 0.
- Div, single requester: req1 ops (3,4,5,7), div=1 → rsp 21/20, id 1, err 0; md_enable_div = 1 throughout WAIT.
- Simultaneous requests:
  - Both valid right after reset, rsp_ready tied 1 → req0 served first, then req1.
  - Hold both valid for 4 ops → rsp_id sequence 0,1,0,1; reqN_ready never both high.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid → rsp_num/den/id/err stable; req0_ready and req1_ready stay 0; one cycle after rsp_ready the next request is accepted.
- Zero denominator: req0 ops (1,2,0,3), div=1 → rsp 3/0, err 1; multiply ops (2,0,5,7) → rsp 10/0, err 1.
- Mid-op reset: assert rst low during WAIT → all outputs 0 immediately, no response after release; a subsequent req1-only request then completes normally with id 1.

Source files
------------

// File: rtl/rat_md_sched.sv
// Two-requester round-robin scheduler in front of a shared rational mul_div unit.
// Accepts one op at a time, waits LATENCY cycles, then returns the tagged result.
module rat_md_sched #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_div,
    input  logic [4*WIDTH-1:0] req0_ops,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_div,
    input  logic [4*WIDTH-1:0] req1_ops,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_num,
    output logic [WIDTH-1:0]   rsp_den,
    output logic               rsp_err,
    output logic               busy,
    output logic               md_enable_div,
    output logic [WIDTH-1:0]   md_l_num,
    output logic [WIDTH-1:0]   md_l_den,
    output logic [WIDTH-1:0]   md_r_num,
    output logic [WIDTH-1:0]   md_r_den,
    input  logic [WIDTH-1:0]   md_s_num,
    input  logic [WIDTH-1:0]   md_s_den
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               last_grant;
    logic               gnt;
    logic               accept;
    logic               gnt_div;
    logic [4*WIDTH-1:0] gnt_ops;

    // On a tie the requester not served last wins; otherwise whoever is valid.
    always_comb begin
        gnt = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        req0_ready = rst & (state == IDLE) & req0_valid & ~gnt;
        req1_ready = rst & (state == IDLE) & req1_valid & gnt;
        accept     = req0_ready | req1_ready;
        gnt_div    = gnt ? req1_div : req0_div;
        gnt_ops    = gnt ? req1_ops : req0_ops;
    end

    assign busy = (state != IDLE);

    // last_grant doubles as the id of the op in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            last_grant    <= 1'b1;
            md_enable_div <= 1'b0;
            md_l_num      <= '0;
            md_l_den      <= '0;
            md_r_num      <= '0;
            md_r_den      <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_num       <= '0;
            rsp_den       <= '0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        md_enable_div <= gnt_div;
                        md_l_num      <= gnt_ops[4*WIDTH-1:3*WIDTH];
                        md_l_den      <= gnt_ops[3*WIDTH-1:2*WIDTH];
                        md_r_num      <= gnt_ops[2*WIDTH-1:WIDTH];
                        md_r_den      <= gnt_ops[WIDTH-1:0];
                        last_grant    <= gnt;
                        cnt           <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        rsp_num   <= md_s_num;
                        rsp_den   <= md_s_den;
                        rsp_err   <= (md_s_den == '0);
                        rsp_id    <= last_grant;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
